// File: rtl/mobo_defs.sv
// Shared encodings for the motherboard bus bridge: control/status bits, FSM states and
// decode targets.
package mobo_defs;

  localparam int unsigned CTRL_READ_BIT  = 0;
  localparam int unsigned CTRL_WRITE_BIT = 1;
  localparam int unsigned STAT_DONE_BIT  = 1;

  localparam logic [1:0] CTRL_READ  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;

  localparam logic [2:0] STAT_IDLE = 3'b001;
  localparam logic [2:0] STAT_DONE = 3'b010;
  localparam logic [2:0] STAT_ERR  = 3'b100;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_DEV_REQ     = 3'd1;
  localparam logic [2:0] ST_DEV_RELEASE = 3'd2;
  localparam logic [2:0] ST_ERR_ADDR    = 3'd3;
  localparam logic [2:0] ST_DONE        = 3'd4;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_VGA,
    TGT_ERR
  } target_e;

endpackage

// File: rtl/addr_decode.sv
// Combinational address map: picks RAM, VGA or unmapped and rebases the address into
// the hit window.
module addr_decode
  import mobo_defs::*;
#(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [WORD_WIDTH-1:0] RAM_SIZE   = 32'h0010_0000,
  parameter logic [WORD_WIDTH-1:0] VGA_BASE   = 32'h0010_0000,
  parameter logic [WORD_WIDTH-1:0] VGA_SIZE   = 32'h0001_0000
) (
  input  logic [WORD_WIDTH-1:0] addr,
  output target_e               target,
  output logic [WORD_WIDTH-1:0] offset
);

  // One extra bit: an address below the base borrows into the MSB, so a single
  // unsigned "offset < size" test covers both window edges.
  logic [WORD_WIDTH:0] ram_off;
  logic [WORD_WIDTH:0] vga_off;
  logic                ram_hit;
  logic                vga_hit;

  always_comb begin
    ram_off = {1'b0, addr} - {1'b0, RAM_BASE};
    vga_off = {1'b0, addr} - {1'b0, VGA_BASE};
    ram_hit = ram_off < {1'b0, RAM_SIZE};
    vga_hit = vga_off < {1'b0, VGA_SIZE};

    target = TGT_ERR;
    offset = '0;
    if (ram_hit) begin
      target = TGT_RAM;
      offset = ram_off[WORD_WIDTH-1:0];
    end else if (vga_hit) begin
      target = TGT_VGA;
      offset = vga_off[WORD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mobo_bus_bridge.sv
// CPU-to-device bus bridge: decodes a CPU request, runs the req/done handshake with RAM
// or VGA over the shared bus and reports completion and read data back to the CPU.
module mobo_bus_bridge
  import mobo_defs::*;
#(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [WORD_WIDTH-1:0] RAM_SIZE   = 32'h0010_0000,
  parameter logic [WORD_WIDTH-1:0] VGA_BASE   = 32'h0010_0000,
  parameter logic [WORD_WIDTH-1:0] VGA_SIZE   = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] cpu_ctrl,
  output logic [WORD_WIDTH-1:0] cpu_stat,
  input  logic [WORD_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic [WORD_WIDTH-1:0] ram_ctrl,
  input  logic [WORD_WIDTH-1:0] ram_stat,
  output logic [WORD_WIDTH-1:0] vga_ctrl,
  input  logic [WORD_WIDTH-1:0] vga_stat,
  output logic [WORD_WIDTH-1:0] dev_addr,
  output logic [WORD_WIDTH-1:0] dev_wdata,
  input  logic [WORD_WIDTH-1:0] dev_rdata
);

  target_e               dec_target;
  logic [WORD_WIDTH-1:0] dec_offset;

  addr_decode #(
    .WORD_WIDTH (WORD_WIDTH),
    .RAM_BASE   (RAM_BASE),
    .RAM_SIZE   (RAM_SIZE),
    .VGA_BASE   (VGA_BASE),
    .VGA_SIZE   (VGA_SIZE)
  ) u_addr_decode (
    .addr   (cpu_addr),
    .target (dec_target),
    .offset (dec_offset)
  );

  logic [2:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  target_e               target_q, target_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] stat_q, stat_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [WORD_WIDTH-1:0] ram_ctrl_q, ram_ctrl_d;
  logic [WORD_WIDTH-1:0] vga_ctrl_q, vga_ctrl_d;

  logic cpu_req;
  logic tgt_done;
  logic unused_stat_bits;

  assign cpu_req          = cpu_ctrl[CTRL_READ_BIT] | cpu_ctrl[CTRL_WRITE_BIT];
  assign tgt_done         = (target_q == TGT_VGA) ? vga_stat[STAT_DONE_BIT]
                                                  : ram_stat[STAT_DONE_BIT];
  assign unused_stat_bits = ^{ram_stat, vga_stat};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    target_d   = target_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    stat_d     = stat_q;
    rdata_d    = rdata_q;
    ram_ctrl_d = ram_ctrl_q;
    vga_ctrl_d = vga_ctrl_q;

    case (state_q)
      ST_IDLE: begin
        stat_d = WORD_WIDTH'(STAT_IDLE);
        if (cpu_req) begin
          // Read has priority when both request bits are set.
          op_d     = cpu_ctrl[CTRL_READ_BIT] ? CTRL_READ : CTRL_WRITE;
          target_d = dec_target;
          addr_d   = dec_offset;
          wdata_d  = cpu_wdata;
          stat_d   = '0;
          if (dec_target == TGT_ERR) begin
            state_d = ST_ERR_ADDR;
          end else begin
            state_d = ST_DEV_REQ;
            if (dec_target == TGT_RAM) begin
              ram_ctrl_d = WORD_WIDTH'(op_d);
            end else begin
              vga_ctrl_d = WORD_WIDTH'(op_d);
            end
          end
        end
      end
      ST_DEV_REQ: begin
        if (tgt_done) begin
          if (op_q == CTRL_READ) begin
            rdata_d = dev_rdata;
          end
          ram_ctrl_d = '0;
          vga_ctrl_d = '0;
          state_d    = ST_DEV_RELEASE;
        end
      end
      ST_DEV_RELEASE: begin
        if (!tgt_done) begin
          stat_d  = WORD_WIDTH'(STAT_DONE);
          state_d = ST_DONE;
        end
      end
      ST_ERR_ADDR: begin
        rdata_d = '1;
        stat_d  = WORD_WIDTH'(STAT_DONE | STAT_ERR);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (cpu_ctrl == '0) begin
          stat_d  = WORD_WIDTH'(STAT_IDLE);
          state_d = ST_IDLE;
        end
      end
      default: begin
        ram_ctrl_d = '0;
        vga_ctrl_d = '0;
        stat_d     = WORD_WIDTH'(STAT_IDLE);
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= CTRL_READ;
      target_q   <= TGT_ERR;
      addr_q     <= '0;
      wdata_q    <= '0;
      stat_q     <= WORD_WIDTH'(STAT_IDLE);
      rdata_q    <= '0;
      ram_ctrl_q <= '0;
      vga_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      target_q   <= target_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      stat_q     <= stat_d;
      rdata_q    <= rdata_d;
      ram_ctrl_q <= ram_ctrl_d;
      vga_ctrl_q <= vga_ctrl_d;
    end
  end

  assign cpu_stat  = stat_q;
  assign cpu_rdata = rdata_q;
  assign ram_ctrl  = ram_ctrl_q;
  assign vga_ctrl  = vga_ctrl_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_mobo_bus_bridge.sv
// Randomized bench for mobo_bus_bridge: scripted RAM/VGA devices plus an address-map and
// memory model computed from the published map and handshake rules.
module tb_mobo_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_ctrl, cpu_stat, cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] ram_ctrl, ram_stat, vga_ctrl, vga_stat;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;

  always #5 clk = ~clk;

  mobo_bus_bridge u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ctrl  (cpu_ctrl),
    .cpu_stat  (cpu_stat),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_ctrl  (ram_ctrl),
    .ram_stat  (ram_stat),
    .vga_ctrl  (vga_ctrl),
    .vga_stat  (vga_stat),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] ram_mem [int unsigned];
  logic [31:0] vga_mem [int unsigned];
  logic [31:0] exp_rdata;

  task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = VGA, 2 = unmapped
  function automatic int ref_target(input logic [31:0] a);
    if (a < 32'h0010_0000) return 0;
    if (a < 32'h0011_0000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ref_offset(input logic [31:0] a);
    case (ref_target(a))
      0:       return a;
      1:       return a - 32'h0010_0000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mem_peek(input int tgt, input logic [31:0] off);
    if (tgt == 0) return ram_mem.exists(off) ? ram_mem[off] : (off ^ 32'h5A5A_0000);
    return vga_mem.exists(off) ? vga_mem[off] : (off ^ 32'hA5A5_F00D);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input int hold,
                         input int dwell, input bit drop_early);
    int          tgt;
    logic [31:0] off, rd, req_word;
    bit          is_read;
    tgt      = ref_target(addr);
    off      = ref_offset(addr);
    is_read  = ctrl[0];
    req_word = is_read ? 32'd1 : 32'd2;

    @(negedge clk);
    cpu_ctrl  = ctrl;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    // Target reports not-done; the other device shows a spurious done bit.
    ram_stat  = (tgt == 1) ? ($urandom | 32'h2) : ($urandom & ~32'h2);
    vga_stat  = (tgt == 1) ? ($urandom & ~32'h2) : ($urandom | 32'h2);
    tick();
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    if (drop_early) cpu_ctrl = 32'h0;

    if (tgt == 2) begin
      check_word("err_ram_ctrl", ram_ctrl, 32'h0);
      check_word("err_vga_ctrl", vga_ctrl, 32'h0);
      check_word("err_busy_stat", cpu_stat, 32'h0);
      tick();
      check_word("err_stat", cpu_stat, 32'h6);
      exp_rdata = 32'hFFFF_FFFF;
      check_word("err_rdata", cpu_rdata, exp_rdata);
      check_word("err_ram_ctrl2", ram_ctrl, 32'h0);
      check_word("err_vga_ctrl2", vga_ctrl, 32'h0);
    end else begin
      check_word("req_tgt_ctrl", (tgt == 0) ? ram_ctrl : vga_ctrl, req_word);
      check_word("req_other_ctrl", (tgt == 0) ? vga_ctrl : ram_ctrl, 32'h0);
      check_word("req_dev_addr", dev_addr, off);
      if (!is_read) check_word("req_dev_wdata", dev_wdata, wdata);
      check_word("req_stat", cpu_stat, 32'h0);
      for (int i = 0; i < lat; i++) begin
        tick();
        check_word("wait_tgt_ctrl", (tgt == 0) ? ram_ctrl : vga_ctrl, req_word);
        check_word("wait_dev_addr", dev_addr, off);
      end
      rd = mem_peek(tgt, off);
      @(negedge clk);
      if (tgt == 0) ram_stat = ram_stat | 32'h2;
      else          vga_stat = vga_stat | 32'h2;
      dev_rdata = rd;
      tick();
      if (is_read) begin
        exp_rdata = rd;
      end else if (tgt == 0) begin
        ram_mem[off] = wdata;
      end else begin
        vga_mem[off] = wdata;
      end
      check_word("ack_ram_ctrl", ram_ctrl, 32'h0);
      check_word("ack_vga_ctrl", vga_ctrl, 32'h0);
      check_word("ack_rdata", cpu_rdata, exp_rdata);
      check_word("ack_stat", cpu_stat, 32'h0);
      for (int i = 0; i < hold; i++) begin
        tick();
        check_word("hold_stat", cpu_stat, 32'h0);
        check_word("hold_dev_addr", dev_addr, off);
      end
      @(negedge clk);
      if (tgt == 0) ram_stat = ram_stat & ~32'h2;
      else          vga_stat = vga_stat & ~32'h2;
      dev_rdata = $urandom;
      tick();
      check_word("done_stat", cpu_stat, 32'h2);
      check_word("done_rdata", cpu_rdata, exp_rdata);
    end

    if (cpu_ctrl != 32'h0) begin
      for (int i = 0; i < dwell; i++) begin
        tick();
        check_word("dwell_stat", cpu_stat, (tgt == 2) ? 32'h6 : 32'h2);
      end
      @(negedge clk);
      cpu_ctrl = 32'h0;
    end
    tick();
    check_word("idle_stat", cpu_stat, 32'h1);
    check_word("idle_rdata", cpu_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0] a, c;
    int          r;
    rst       = 1'b1;
    cpu_ctrl  = 32'h0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    ram_stat  = 32'h0;
    vga_stat  = 32'h0;
    dev_rdata = 32'h0;
    exp_rdata = 32'h0;
    #12;
    check_word("rst_stat", cpu_stat, 32'h1);
    check_word("rst_rdata", cpu_rdata, 32'h0);
    check_word("rst_ram_ctrl", ram_ctrl, 32'h0);
    check_word("rst_vga_ctrl", vga_ctrl, 32'h0);
    check_word("rst_dev_addr", dev_addr, 32'h0);
    check_word("rst_dev_wdata", dev_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_word("post_rst_stat", cpu_stat, 32'h1);

    run_txn(32'h2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 2, 1'b0);
    vga_mem[32'h4] = 32'h0000_1234;
    run_txn(32'h1, 32'h0010_0004, 32'h0, 1, 0, 1, 1'b0);
    run_txn(32'h1, 32'h0020_0000, 32'h0, 0, 0, 1, 1'b0);
    run_txn(32'h1, 32'h000F_FFFF, 32'h0, 1, 1, 0, 1'b0);
    run_txn(32'h2, 32'h0010_0000, 32'h1357_9BDF, 0, 0, 0, 1'b0);
    run_txn(32'h1, 32'h0010_0000, 32'h0, 2, 0, 0, 1'b0);
    run_txn(32'h1, 32'h0011_0000, 32'h0, 0, 0, 0, 1'b0);
    run_txn(32'h2, 32'h0000_0200, 32'hCAFE_F00D, 0, 0, 0, 1'b0);
    run_txn(32'h3, 32'h0000_0200, 32'h1111_1111, 0, 0, 0, 1'b0);
    run_txn(32'h1, 32'h0000_0200, 32'h0, 0, 0, 0, 1'b0);
    run_txn(32'h1, 32'h0000_0300, 32'h0, 0, 3, 1, 1'b0);
    run_txn(32'h2, 32'h0000_0400, 32'h2468_ACE0, 2, 1, 0, 1'b1);

    // Nonzero control with neither request bit is ignored.
    @(negedge clk);
    cpu_ctrl = 32'h4;
    cpu_addr = 32'h0000_0040;
    tick();
    check_word("ign_stat", cpu_stat, 32'h1);
    check_word("ign_ram_ctrl", ram_ctrl, 32'h0);
    tick();
    check_word("ign_stat2", cpu_stat, 32'h1);
    @(negedge clk);
    cpu_ctrl = 32'h0;

    // Asynchronous reset in the middle of a RAM request.
    @(negedge clk);
    cpu_ctrl = 32'h1;
    cpu_addr = 32'h0000_0080;
    ram_stat = 32'h0;
    tick();
    check_word("pre_rst_ram_ctrl", ram_ctrl, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_word("async_rst_ram_ctrl", ram_ctrl, 32'h0);
    check_word("async_rst_stat", cpu_stat, 32'h1);
    check_word("async_rst_rdata", cpu_rdata, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst      = 1'b0;
    cpu_ctrl = 32'h0;
    tick();
    check_word("rel_rst_stat", cpu_stat, 32'h1);
    check_word("rel_rst_ram_ctrl", ram_ctrl, 32'h0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = 32'h0000_0000 + ($urandom_range(0, 15) * 4);
        1:       a = 32'h0010_0000 + ($urandom_range(0, 15) * 4);
        2:       a = 32'h0011_0000 + ($urandom % 32'hFFEF_0000);
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h000F_FFFF;
            1:       a = 32'h0010_0000;
            2:       a = 32'h0010_FFFF;
            default: a = 32'h0011_0000;
          endcase
        end
      endcase
      c = 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) c = c | ($urandom & 32'hFFFF_FFF0);
      run_txn(c, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
